// File: rtl/metronome_ctrl.sv
// Metronome sequencing controller: tempo/meter state, beat timing and a
// serial restoring divider that turns BPM into a beat period in clock cycles.
module metronome_ctrl #(
    parameter int unsigned CLK_HZ        = 50_000_000,
    parameter int unsigned BPM_MIN       = 30,
    parameter int unsigned BPM_MAX       = 250,
    parameter int unsigned BPM_DEFAULT   = 120,
    parameter int unsigned METER_DEFAULT = 4,
    parameter int unsigned METER_MAX     = 7
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_btn_meter,
    input  logic       i_btn_run,
    output logic [7:0] o_bpm,
    output logic [2:0] o_meter,
    output logic [2:0] o_beat_idx,
    output logic       o_beat,
    output logic       o_downbeat,
    output logic       o_running,
    output logic       o_busy
);

    localparam logic [0:0] ST_STOP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [31:0] DIVIDEND   = 32'(CLK_HZ * 32'd60);
    localparam logic [31:0] PERIOD_RST = DIVIDEND / 32'(BPM_DEFAULT);
    localparam logic [7:0]  BPM_LO     = 8'(BPM_MIN);
    localparam logic [7:0]  BPM_HI     = 8'(BPM_MAX);
    localparam logic [7:0]  BPM_RST    = 8'(BPM_DEFAULT);
    localparam logic [2:0]  METER_HI   = 3'(METER_MAX);
    localparam logic [2:0]  METER_RST  = 3'(METER_DEFAULT);

    logic [0:0]  state_q, state_d;
    logic [7:0]  bpm_q, bpm_d;
    logic [2:0]  meter_q, meter_d;
    logic [2:0]  idx_q, idx_d;
    logic        beat_q, beat_d;
    logic        downbeat_q, downbeat_d;
    logic [31:0] count_q, count_d;
    logic [31:0] period_q, period_d;
    logic        busy_q, busy_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;

    logic        up_ok;
    logic        dn_ok;
    logic [32:0] trial;
    logic        trial_ge;
    logic [32:0] cnt_inc;
    logic        beat_due;
    logic [2:0]  meter_last;

    always_comb begin
        up_ok      = i_btn_up & ~i_btn_down & (bpm_q < BPM_HI);
        dn_ok      = i_btn_down & ~i_btn_up & (bpm_q > BPM_LO);
        trial      = {rem_q, quo_q[31]} - {25'd0, bpm_q};
        trial_ge   = ~trial[32];
        // Widened increment keeps the compare safe if the period shrinks.
        cnt_inc    = {1'b0, count_q} + 33'd1;
        beat_due   = cnt_inc >= {1'b0, period_q};
        meter_last = meter_q - 3'd1;
    end

    always_comb begin
        bpm_d     = bpm_q;
        busy_d    = busy_q;
        div_cnt_d = div_cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        period_d  = period_q;

        if (busy_q) begin
            rem_d     = trial_ge ? trial[31:0] : {rem_q[30:0], quo_q[31]};
            quo_d     = {quo_q[30:0], trial_ge};
            div_cnt_d = div_cnt_q + 5'd1;
            if (div_cnt_q == 5'd31) begin
                busy_d   = 1'b0;
                period_d = {quo_q[30:0], trial_ge};
            end
        end else if (up_ok | dn_ok) begin
            bpm_d     = up_ok ? bpm_q + 8'd1 : bpm_q - 8'd1;
            busy_d    = 1'b1;
            div_cnt_d = 5'd0;
            rem_d     = 32'd0;
            quo_d     = DIVIDEND;
        end
    end

    always_comb begin
        meter_d = meter_q;
        if (i_btn_meter) begin
            meter_d = (meter_q >= METER_HI) ? 3'd1 : meter_q + 3'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        beat_d     = 1'b0;
        downbeat_d = 1'b0;

        case (state_q)
            ST_STOP: begin
                count_d = 32'd0;
                if (i_btn_run) begin
                    state_d    = ST_RUN;
                    idx_d      = 3'd0;
                    beat_d     = 1'b1;
                    downbeat_d = 1'b1;
                end
            end
            ST_RUN: begin
                // A run toggle overrides a beat falling due in the same cycle.
                if (i_btn_run) begin
                    state_d = ST_STOP;
                    count_d = 32'd0;
                    idx_d   = 3'd0;
                end else if (beat_due) begin
                    count_d = 32'd0;
                    beat_d  = 1'b1;
                    if (idx_q >= meter_last) begin
                        idx_d      = 3'd0;
                        downbeat_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    count_d = cnt_inc[31:0];
                end
            end
            default: begin
                state_d = ST_STOP;
                count_d = 32'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_STOP;
            bpm_q      <= BPM_RST;
            meter_q    <= METER_RST;
            idx_q      <= 3'd0;
            beat_q     <= 1'b0;
            downbeat_q <= 1'b0;
            count_q    <= 32'd0;
            period_q   <= PERIOD_RST;
            busy_q     <= 1'b0;
            div_cnt_q  <= 5'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            bpm_q      <= bpm_d;
            meter_q    <= meter_d;
            idx_q      <= idx_d;
            beat_q     <= beat_d;
            downbeat_q <= downbeat_d;
            count_q    <= count_d;
            period_q   <= period_d;
            busy_q     <= busy_d;
            div_cnt_q  <= div_cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
        end
    end

    assign o_bpm      = bpm_q;
    assign o_meter    = meter_q;
    assign o_beat_idx = idx_q;
    assign o_beat     = beat_q;
    assign o_downbeat = downbeat_q;
    assign o_running  = (state_q == ST_RUN);
    assign o_busy     = busy_q;

endmodule
